// File: rtl/video_pattern_gen.sv
// Parallel-video test pattern transmitter.
// Produces VBL / ACT / HBL framing on vs_o/hs_o/de_o with a selectable pattern.
// Configuration is captured once per frame. All outputs are registered.
module video_pattern_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 12,
    parameter int FRCNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [CNT_WIDTH-1:0]   cfg_pix_i,
    input  logic [CNT_WIDTH-1:0]   cfg_row_i,
    input  logic [CNT_WIDTH-1:0]   cfg_hbl_i,
    input  logic [CNT_WIDTH-1:0]   cfg_vbl_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic [DATA_WIDTH-1:0]  cfg_const_i,
    output logic [DATA_WIDTH-1:0]  do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   sof_o,
    output logic                   busy_o,
    output logic [FRCNT_WIDTH-1:0] frame_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_VBL, S_ACT, S_HBL} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;   // phase cycle counter; equals x in ACT
    logic [CNT_WIDTH-1:0]   r_y, w_y_nxt;
    logic                   w_latch, w_frame_done;

    // Per-frame configuration snapshot
    logic [CNT_WIDTH-1:0]   r_pix, r_row, r_hbl, r_vbl;
    logic [1:0]             r_mode;
    logic [DATA_WIDTH-1:0]  r_const;

    // Output registers
    logic [DATA_WIDTH-1:0]  r_do;
    logic                   r_de, r_hs, r_vs, r_sof, r_busy;
    logic [FRCNT_WIDTH-1:0] r_frame_cnt;

    // Next-value terms of the output registers
    logic [DATA_WIDTH-1:0]  w_do_nxt;
    logic                   w_de_nxt, w_hs_nxt, w_vs_nxt, w_sof_nxt, w_busy_nxt;

    // Next-state and counter logic for the framing FSM
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_y_nxt      = r_y;
        w_latch      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_VBL;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = '0;
                end
            end
            S_VBL: begin
                w_y_nxt = '0;
                if (r_cnt == r_vbl - ONE) begin
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            S_ACT: begin
                if (r_cnt == r_pix - ONE) begin
                    w_state_nxt = S_HBL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            S_HBL: begin
                if (r_cnt != r_hbl - ONE) begin
                    w_cnt_nxt = r_cnt + ONE;
                end else if (r_y < r_row - ONE) begin
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = r_y + ONE;
                end else begin
                    // Last line done: the frame closes; en_i decides run-on or stop.
                    w_frame_done = 1'b1;
                    w_cnt_nxt    = '0;
                    w_y_nxt      = '0;
                    if (en_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_VBL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with r_state
    always_comb begin
        w_de_nxt   = (w_state_nxt == S_ACT);
        w_hs_nxt   = (w_state_nxt != S_ACT);
        w_vs_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_VBL);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_sof_nxt  = w_de_nxt && (w_cnt_nxt == '0) && (w_y_nxt == '0);
        w_do_nxt   = '0;
        if (w_de_nxt) begin
            case (r_mode)
                2'd0:    w_do_nxt = DATA_WIDTH'(w_cnt_nxt);
                2'd1:    w_do_nxt = DATA_WIDTH'(w_y_nxt);
                2'd2:    w_do_nxt = DATA_WIDTH'(w_cnt_nxt) + DATA_WIDTH'(w_y_nxt)
                                  + DATA_WIDTH'(r_frame_cnt);
                default: w_do_nxt = r_const;
            endcase
        end
    end

    // FSM state and position counters
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Configuration snapshot at each frame start; zero sizes clamp to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix   <= ONE;
            r_row   <= ONE;
            r_hbl   <= ONE;
            r_vbl   <= ONE;
            r_mode  <= 2'd0;
            r_const <= '0;
        end else if (w_latch) begin
            r_pix   <= (cfg_pix_i == '0) ? ONE : cfg_pix_i;
            r_row   <= (cfg_row_i == '0) ? ONE : cfg_row_i;
            r_hbl   <= (cfg_hbl_i == '0) ? ONE : cfg_hbl_i;
            r_vbl   <= (cfg_vbl_i == '0) ? ONE : cfg_vbl_i;
            r_mode  <= cfg_mode_i;
            r_const <= cfg_const_i;
        end
    end

    // Registered video outputs and completed-frame counter (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do        <= '0;
            r_de        <= 1'b0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_sof       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_do   <= w_do_nxt;
            r_de   <= w_de_nxt;
            r_hs   <= w_hs_nxt;
            r_vs   <= w_vs_nxt;
            r_sof  <= w_sof_nxt;
            r_busy <= w_busy_nxt;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + FRCNT_WIDTH'(1);
            end
        end
    end

    assign do_o        = r_do;
    assign de_o        = r_de;
    assign hs_o        = r_hs;
    assign vs_o        = r_vs;
    assign sof_o       = r_sof;
    assign busy_o      = r_busy;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: a frame-position model predicts
// every output each cycle; directed scenarios add hand-computed expectations.
module tb_video_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        en_i;
    logic [11:0] cfg_pix_i, cfg_row_i, cfg_hbl_i, cfg_vbl_i;
    logic [1:0]  cfg_mode_i;
    logic [7:0]  cfg_const_i;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o, sof_o, busy_o;
    logic [15:0] frame_cnt_o;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 0;

    video_pattern_gen #(.DATA_WIDTH(8), .CNT_WIDTH(12), .FRCNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i),
        .cfg_pix_i(cfg_pix_i), .cfg_row_i(cfg_row_i), .cfg_hbl_i(cfg_hbl_i),
        .cfg_vbl_i(cfg_vbl_i), .cfg_mode_i(cfg_mode_i), .cfg_const_i(cfg_const_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cl(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Behavioural model: a running flag plus the cycle offset inside the current frame.
    bit m_run;
    int m_t, m_len, m_pix, m_hbl, m_vbl, m_mode, m_const, m_frames;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 0;
            m_t      <= 0;
            m_frames <= 0;
        end else begin
            if (m_run && (m_t + 1 == m_len)) m_frames <= (m_frames + 1) % 65536;
            if ((!m_run && en_i) || (m_run && (m_t + 1 == m_len) && en_i)) begin
                m_run   <= 1;
                m_t     <= 0;
                m_pix   <= cl(int'(cfg_pix_i));
                m_hbl   <= cl(int'(cfg_hbl_i));
                m_vbl   <= cl(int'(cfg_vbl_i));
                m_mode  <= int'(cfg_mode_i);
                m_const <= int'(cfg_const_i);
                m_len   <= cl(int'(cfg_vbl_i))
                         + cl(int'(cfg_row_i)) * (cl(int'(cfg_pix_i)) + cl(int'(cfg_hbl_i)));
            end else if (m_run && (m_t + 1 == m_len)) begin
                m_run <= 0;
                m_t   <= 0;
            end else if (m_run) begin
                m_t <= m_t + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    int e_de, e_hs, e_vs, e_sof, e_busy, e_do, e_u, e_ln, e_y, e_x;
    always @(negedge clk) begin
        if (cmp_on) begin
            e_de = 0; e_hs = 1; e_vs = 1; e_sof = 0; e_busy = 0; e_do = 0;
            if (m_run) begin
                e_busy = 1;
                if (m_t >= m_vbl) begin
                    e_u  = m_t - m_vbl;
                    e_ln = m_pix + m_hbl;
                    e_y  = e_u / e_ln;
                    e_x  = e_u % e_ln;
                    e_vs = 0;
                    if (e_x < m_pix) begin
                        e_de  = 1;
                        e_hs  = 0;
                        e_sof = (e_x == 0 && e_y == 0) ? 1 : 0;
                        case (m_mode)
                            0:       e_do = e_x % 256;
                            1:       e_do = e_y % 256;
                            2:       e_do = (e_x + e_y + m_frames) % 256;
                            default: e_do = m_const;
                        endcase
                    end
                end
            end
            check("de",        int'(de_o),        e_de);
            check("hs",        int'(hs_o),        e_hs);
            check("vs",        int'(vs_o),        e_vs);
            check("sof",       int'(sof_o),       e_sof);
            check("busy",      int'(busy_o),      e_busy);
            check("do",        int'(do_o),        e_do);
            check("frame_cnt", int'(frame_cnt_o), m_frames);
        end
    end

    // Capture buffers for hand-computed checks; index 0 = first cycle after en_i is sampled
    logic [7:0]  cap_do  [0:199];
    logic        cap_de  [0:199];
    logic        cap_hs  [0:199];
    logic        cap_vs  [0:199];
    logic        cap_sof [0:199];
    logic        cap_bsy [0:199];
    logic [15:0] cap_fc  [0:199];

    task automatic run_capture(input int n, input int drop_at, input int chg_at,
                               input logic [11:0] new_pix);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_do[k]  = do_o;
            cap_de[k]  = de_o;
            cap_hs[k]  = hs_o;
            cap_vs[k]  = vs_o;
            cap_sof[k] = sof_o;
            cap_bsy[k] = busy_o;
            cap_fc[k]  = frame_cnt_o;
            if (k == drop_at) en_i = 1'b0;
            if (k == chg_at)  cfg_pix_i = new_pix;
        end
    endtask

    function automatic int count_de(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) c += int'(cap_de[k]);
        return c;
    endfunction

    function automatic int count_sof(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) c += int'(cap_sof[k]);
        return c;
    endfunction

    task automatic do_reset();
        en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int pix, input int row, input int hbl, input int vbl,
                           input int mode, input int cval);
        cfg_pix_i   = 12'(pix);
        cfg_row_i   = 12'(row);
        cfg_hbl_i   = 12'(hbl);
        cfg_vbl_i   = 12'(vbl);
        cfg_mode_i  = 2'(mode);
        cfg_const_i = 8'(cval);
    endtask

    initial begin
        rst_n = 1'b1;
        en_i  = 1'b0;
        set_cfg(8, 4, 3, 5, 0, 0);
        #1 rst_n = 1'b0;
        cmp_on = 1;
        @(negedge clk);
        check("reset_hs",   int'(hs_o), 1);
        check("reset_vs",   int'(vs_o), 1);
        check("reset_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: mode0 framing, en held
        en_i = 1'b1;
        run_capture(60, -1, -1, 12'd0);
        check("t1_vbl_c0",  int'(cap_vs[0]) + int'(cap_bsy[0]), 2);
        check("t1_vbl_c4",  int'(cap_vs[4]), 1);
        check("t1_act_c5",  int'(cap_vs[5]), 0);
        check("t1_sof_c5",  int'(cap_sof[5]), 1);
        check("t1_do_c5",   int'(cap_do[5]), 0);
        check("t1_do_c12",  int'(cap_do[12]), 7);
        check("t1_hbl_c13", int'(cap_hs[13]) * 2 + int'(cap_de[13]), 2);
        check("t1_hbl_c48", int'(cap_hs[48]) * 2 + int'(cap_vs[48]), 2);
        check("t1_vs_c49",  int'(cap_vs[49]), 1);
        check("t1_fc_c48",  int'(cap_fc[48]), 0);
        check("t1_fc_c49",  int'(cap_fc[49]), 1);
        check("t1_de_cnt",  count_de(0, 48), 32);
        check("t1_sof_cnt", count_sof(0, 48), 1);

        // T2: mode1 then mode2
        do_reset();
        set_cfg(8, 4, 3, 5, 1, 0);
        en_i = 1'b1;
        run_capture(60, -1, -1, 12'd0);
        check("t2_y_line2", int'(cap_do[5 + 2 * 11 + 3]), 2);
        check("t2_y_line3", int'(cap_do[5 + 3 * 11 + 7]), 3);
        do_reset();
        set_cfg(8, 4, 3, 5, 2, 0);
        en_i = 1'b1;
        run_capture(150, -1, -1, 12'd0);
        check("t2_xyf_f0", int'(cap_do[5 + 3 * 11 + 6]), 9);
        check("t2_xyf_f2", int'(cap_do[2 * 49 + 5 + 11 + 4]), 7);
        check("t2_xyf_f1", int'(cap_do[49 + 5 + 3 * 11 + 7]), 11);

        // T3: all-zero config clamps to a 3-cycle frame
        do_reset();
        set_cfg(0, 0, 0, 0, 0, 0);
        en_i = 1'b1;
        run_capture(10, -1, -1, 12'd0);
        check("t3_de_c1",  int'(cap_de[1]), 1);
        check("t3_de_c4",  int'(cap_de[4]), 1);
        check("t3_de_c7",  int'(cap_de[7]), 1);
        check("t3_sof_c4", int'(cap_sof[4]), 1);
        check("t3_fc_c3",  int'(cap_fc[3]), 1);
        check("t3_fc_c6",  int'(cap_fc[6]), 2);

        // T4: en dropped during line 2, frame still completes then IDLE
        do_reset();
        set_cfg(8, 4, 3, 5, 0, 0);
        en_i = 1'b1;
        run_capture(60, 30, -1, 12'd0);
        check("t4_de_cnt", count_de(0, 48), 32);
        check("t4_idle_vs", int'(cap_vs[55]) + int'(cap_hs[55]), 2);
        check("t4_idle_busy", int'(cap_bsy[55]), 0);
        check("t4_idle_fc", int'(cap_fc[55]), 1);

        // T5: cfg_pix changes mid-frame, applies next frame
        do_reset();
        set_cfg(8, 4, 3, 5, 0, 0);
        en_i = 1'b1;
        run_capture(135, -1, 20, 12'd16);
        check("t5_f0_de", count_de(0, 48), 32);
        check("t5_f1_de", count_de(49, 129), 64);
        check("t5_f1_x15", int'(cap_do[49 + 5 + 15]), 15);
        check("t5_vs_130", int'(cap_vs[130]), 1);
        set_cfg(8, 4, 3, 5, 0, 0);

        // T6: async reset mid-ACT of frame 1
        do_reset();
        en_i = 1'b1;
        run_capture(57, -1, -1, 12'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_de", int'(de_o), 0);
        check("t6_rst_hsvs", int'(hs_o) + int'(vs_o), 2);
        check("t6_rst_fc", int'(frame_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_capture(20, -1, -1, 12'd0);
        check("t6_vbl_c4", int'(cap_vs[4]) * 2 + int'(cap_de[4]), 2);
        check("t6_sof_c5", int'(cap_sof[5]), 1);
        check("t6_de_pre", count_de(0, 4), 0);

        // Randomized run: config churn, en toggling, occasional async reset pulses
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 4),
                        $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 255));
            end
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
